// File: rtl/cla_pipe_adder_if.sv
`timescale 1ns/1ps
// cla_pipe_adder_if: operand stream in, result stream out for the pipelined CLA.
// The master drives operands and consumes results; the slave is the adder.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf, zero
    );
endinterface

// File: rtl/cla_pipe_adder.sv
`timescale 1ns/1ps
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor on a valid/ready
// stream. One GROUP-bit lookahead group is resolved per stage; the group carry
// is registered between stages, so latency is WIDTH/GROUP cycles at one beat
// per cycle. Optional macro CLA_PIPE_SAT_EN clamps overflowing results to the
// signed limit; without it the sum wraps.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input logic             clk,
    input logic             rst,
    cla_pipe_adder_if.slave bus
);
    localparam int GSAFE = (GROUP < 1) ? 1 : GROUP;
    localparam int NSTG  = (WIDTH / GSAFE < 1) ? 1 : WIDTH / GSAFE;

    if (GROUP < 1 || (WIDTH % GSAFE) != 0) begin : g_cfg_check
        $error("cla_pipe_adder: WIDTH (%0d) must be a positive multiple of GROUP (%0d)",
               WIDTH, GROUP);
    end

    // One pipeline register. Operand bits still to be added sit LSB-aligned
    // and shift down by GROUP per stage; finished sum slices enter at the top
    // and shift down, so after NSTG stages the sum is fully aligned.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a;      // remaining bits of A
        logic [WIDTH-1:0] b;      // remaining bits of effective B (already inverted for sub)
        logic             carry;  // carry into next group; carry out of MSB at the last stage
        logic [WIDTH-1:0] sum;    // finished slices, filling from the top
        logic             ovf;    // meaningful at the last stage only
        logic             zero;   // meaningful at the last stage only
    } stage_t;

    // Group lookahead: every carry is a sum of products of the group's
    // generate/propagate terms and the incoming carry, with no ripple chain.
    // Returns {carry into group MSB, carry out of group, sum slice}.
    function automatic logic [GROUP+1:0] cla_group(
        input logic [GROUP-1:0] x,
        input logic [GROUP-1:0] y,
        input logic             cin
    );
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   gg;  // gg[0] = cin, gg[j+1] = g[j]
        logic [GROUP:0]   c;
        logic             term;
        g     = x & y;
        p     = x ^ y;
        gg    = {g, cin};
        c     = '0;
        c[0]  = cin;
        for (int i = 0; i < GROUP; i++) begin
            for (int j = 0; j <= i + 1; j++) begin
                term = gg[j];
                for (int m = j; m <= i; m++) begin
                    term = term & p[m];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[GROUP-1], c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    stage_t           stg_q [NSTG];
    stage_t           stg_d [NSTG];
    stage_t           src;
    logic [GROUP+1:0] grp;
    logic [WIDTH-1:0] sum_next;
    logic             advance;

    // A single stall line: everything moves unless a result is waiting.
    assign advance      = !stg_q[NSTG-1].valid || bus.out_ready;
    assign bus.in_ready = advance;

    assign bus.out_valid = stg_q[NSTG-1].valid;
    assign bus.sum       = stg_q[NSTG-1].sum;
    assign bus.c_out     = stg_q[NSTG-1].carry;
    assign bus.ovf       = stg_q[NSTG-1].ovf;
    assign bus.zero      = stg_q[NSTG-1].zero;

    // Next-state of every stage: one lookahead group each, flags at the last.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves one unassigned, which would otherwise infer a latch.
        src      = '0;
        grp      = '0;
        sum_next = '0;
        for (int k = 0; k < NSTG; k++) begin
            if (k == 0) begin
                src       = '0;
                src.valid = bus.in_valid;
                src.a     = bus.a;
                src.b     = bus.sub ? ~bus.b : bus.b;
                src.carry = bus.sub ? ~bus.c_in : bus.c_in;
            end else begin
                src = stg_q[(k == 0) ? 0 : k - 1];
            end

            grp      = cla_group(src.a[GROUP-1:0], src.b[GROUP-1:0], src.carry);
            sum_next = src.sum >> GROUP;
            sum_next[WIDTH-1 -: GROUP] = grp[GROUP-1:0];

            stg_d[k]       = '0;
            stg_d[k].valid = src.valid;
            stg_d[k].a     = src.a >> GROUP;
            stg_d[k].b     = src.b >> GROUP;
            stg_d[k].carry = grp[GROUP];

            if (k == NSTG - 1) begin
                stg_d[k].ovf = grp[GROUP+1] ^ grp[GROUP];
`ifdef CLA_PIPE_SAT_EN
                // Overflow only happens with equal operand signs, so A's sign
                // gives the direction of the true result.
                if (stg_d[k].ovf) begin
                    sum_next = src.a[GROUP-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                              : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
                stg_d[k].zero = (sum_next == '0);
            end
            stg_d[k].sum = sum_next;
        end
    end

    // Pipeline registers; the whole pipe advances together or holds together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: data fields are cleared along with the valid bits because
            // the last stage drives the result ports, which read zero in reset.
            for (int k = 0; k < NSTG; k++) begin
                stg_q[k] <= '0;
            end
        end else if (advance) begin
            // NOTE: non-blocking so each stage samples its neighbour's old value.
            for (int k = 0; k < NSTG; k++) begin
                stg_q[k] <= stg_d[k];
            end
        end
    end
endmodule

// File: tb/tb_cla_pipe_adder.sv
`timescale 1ns/1ps
// tb_cla_pipe_adder: directed and randomized checks of the pipelined CLA
// (WIDTH=16, GROUP=4, latency 4) against an integer-arithmetic reference.
module tb_cla_pipe_adder;
    localparam int W   = 16;
    localparam int LAT = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         c_out;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    cla_pipe_adder_if #(.WIDTH(W)) bus ();

    cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: plain signed/unsigned integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t       e;
        int         sa;
        int         sb;
        int         sres;
        logic [W:0] u;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            sres    = sa - sb - int'(cin);
            u       = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
            e.c_out = ~u[W];
        end else begin
            sres    = sa + sb + int'(cin);
            u       = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            e.c_out = u[W];
        end
        e.sum = u[W-1:0];
        e.ovf = (sres > 32767) || (sres < -32768);
`ifdef CLA_PIPE_SAT_EN
        if (e.ovf) e.sum = (sres > 0) ? 16'h7FFF : 16'h8000;
`endif
        e.zero = (e.sum == '0);
        return e;
    endfunction

    // Send one beat with the consumer always ready and check latency and result.
    task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub, input logic [W-1:0] esum,
                           input logic ec, input logic eo, input logic ez);
        int lat;
        bit seen;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.c_in      = cin;
        bus.sub       = sub;
        bus.out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #1;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 20) begin
            if (bus.out_valid) seen = 1'b1;
            else begin
                @(posedge clk); #2;
                lat++;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        if (seen) begin
            check({tag, "_sum"},   32'(bus.sum),   32'(esum));
            check({tag, "_c_out"}, 32'(bus.c_out), 32'(ec));
            check({tag, "_ovf"},   32'(bus.ovf),   32'(eo));
            check({tag, "_zero"},  32'(bus.zero),  32'(ez));
        end
    endtask

    initial begin : main
        exp_t         q[$];
        exp_t         e;
        logic [19:0]  snap;
        bit           stall_pending;
        bit           pending;
        bit           acc;
        bit           saw_valid;
        int           accepted;
        int           consumed;
        int           cycles;
        logic [W-1:0] sat_pos;
        logic [W-1:0] sat_neg;

`ifdef CLA_PIPE_SAT_EN
        sat_pos = 16'h7FFF;
        sat_neg = 16'h8000;
`else
        sat_pos = 16'h8000;
        sat_neg = 16'h7FFF;
`endif

        // Power-on reset, then idle traffic-free cycles.
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        // 1. Reset for 3 cycles mid-idle; consumer not ready at release.
        #1;
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum",       32'(bus.sum),       32'd0);
        check("rst_c_out",     32'(bus.c_out),     32'd0);
        check("rst_ovf",       32'(bus.ovf),       32'd0);
        check("rst_zero",      32'(bus.zero),      32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);

        // 2. Carries crossing group boundaries.
        run_one("xgroup",  16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_one("wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        // 3. Signed overflow on add.
        run_one("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, sat_pos,  1'b0, 1'b1, 1'b0);
        // 4. Subtraction, with and without overflow.
        run_one("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_one("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, sat_neg,  1'b1, 1'b1, 1'b0);
        run_one("sub_bin", 16'h0010, 16'h0010, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);

        // 5. Random stream with random valid and backpressure.
        accepted      = 0;
        consumed      = 0;
        cycles        = 0;
        pending       = 1'b0;
        stall_pending = 1'b0;
        snap          = '0;
        while ((accepted < 1000 || q.size() > 0 || bus.out_valid) && cycles < 20000) begin
            @(posedge clk); #1;
            cycles++;
            if (stall_pending) begin
                check("stall_hold", 32'({bus.out_valid, bus.sum, bus.c_out, bus.ovf, bus.zero}),
                      32'(snap));
                stall_pending = 1'b0;
            end
            if (!pending) begin
                if (accepted < 1000 && ($urandom() % 2) == 0) begin
                    bus.in_valid = 1'b1;
                    bus.a        = 16'($urandom());
                    bus.b        = 16'($urandom());
                    bus.c_in     = 1'($urandom());
                    bus.sub      = 1'($urandom());
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = 1'($urandom());
            #1;
            acc = bus.in_valid && bus.in_ready;
            if (acc) begin
                q.push_back(model(bus.a, bus.b, bus.c_in, bus.sub));
                accepted++;
            end
            if (bus.out_valid && bus.out_ready) begin
                check("stream_expected_present", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("stream_sum",   32'(bus.sum),   32'(e.sum));
                    check("stream_c_out", 32'(bus.c_out), 32'(e.c_out));
                    check("stream_ovf",   32'(bus.ovf),   32'(e.ovf));
                    check("stream_zero",  32'(bus.zero),  32'(e.zero));
                end
                consumed++;
            end
            if (bus.out_valid && !bus.out_ready) begin
                snap          = {bus.out_valid, bus.sum, bus.c_out, bus.ovf, bus.zero};
                stall_pending = 1'b1;
            end
            pending = bus.in_valid && !acc;
        end
        bus.in_valid = 1'b0;
        check("stream_accepted", 32'(accepted), 32'd1000);
        check("stream_consumed", 32'(consumed), 32'(accepted));
        check("stream_leftover", 32'(q.size()), 32'd0);

        // 6. Reset while three beats are in flight, before any result.
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 16'($urandom());
            bus.b        = 16'($urandom());
            bus.c_in     = 1'b0;
            bus.sub      = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("midrst_pre_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.out_valid) saw_valid = 1'b1;
        end
        check("midrst_no_stale", 32'(saw_valid), 32'd0);
        run_one("post_rst", 16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
